// File: rtl/minhash_sorter_pkg.sv
// Shared types and default sizes for the MinHash selection stage.
package minhash_sorter_pkg;

    localparam int SORTER_EXTENDER_INDICES_COUNT = 4;
    localparam int HASHER_SORTER_SIGNATURE       = 32;
    localparam int INDICE_LEN                    = 5;

    // One hasher beat: signature in the upper bits, k-mer index below it.
    typedef struct packed {
        logic [HASHER_SORTER_SIGNATURE-1:0] signature;
        logic [INDICE_LEN-1:0]              index;
    } signature_index_pack;

    // One entry of the sorted table.
    typedef struct packed {
        logic                               valid;
        logic [HASHER_SORTER_SIGNATURE-1:0] signature;
        logic [INDICE_LEN-1:0]              index;
    } sorter_slot;

    typedef enum logic {
        COLLECT = 1'b0,
        OUTPUT  = 1'b1
    } sorter_state_e;

    function automatic signature_index_pack pack_sig(
        input logic [HASHER_SORTER_SIGNATURE-1:0] sig,
        input logic [INDICE_LEN-1:0]              idx
    );
        return {sig, idx};
    endfunction

endpackage

// File: rtl/minhash_sorter_if.sv
// Hasher-side beat stream and extender-side result handshake of the sorter.
interface minhash_sorter_if #(
    parameter int K     = minhash_sorter_pkg::SORTER_EXTENDER_INDICES_COUNT,
    parameter int SIG_W = minhash_sorter_pkg::HASHER_SORTER_SIGNATURE,
    parameter int IDX_W = minhash_sorter_pkg::INDICE_LEN,
    parameter int CNT_W = $clog2(K+1)
);
    logic                   in_valid;
    logic                   in_ready;
    logic [SIG_W+IDX_W-1:0] in_data;
    logic                   in_last;
    logic                   out_valid;
    logic                   out_ready;
    logic [K*IDX_W-1:0]     out_indices;
    logic [CNT_W-1:0]       out_count;

    // Environment side: hasher driving beats, extender consuming results.
    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_indices, out_count
    );

    // Sorter side.
    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_indices, out_count
    );
endinterface

// File: rtl/minhash_sorter_slot_cell.sv
// One slot of the sorted table. It compares its own signature against the
// incoming one and picks hold, shift-from-below or load-new. The le outputs
// of all slots form a thermometer code: ones below the insertion point.
module sorter_slot_cell #(
    parameter int SIG_W = 32,
    parameter int IDX_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             ins,
    input  logic [SIG_W-1:0] new_sig,
    input  logic [IDX_W-1:0] new_idx,
    input  logic             below_le,
    input  logic             below_valid,
    input  logic [SIG_W-1:0] below_sig,
    input  logic [IDX_W-1:0] below_idx,
    output logic             le,
    output logic             valid_q,
    output logic [SIG_W-1:0] sig_q,
    output logic [IDX_W-1:0] idx_q,
    output logic             valid_d,
    output logic [IDX_W-1:0] idx_d
);
    logic [SIG_W-1:0] sig_d;

    // Keeping "<=" makes an equal later arrival land above the earlier one.
    assign le = valid_q && (sig_q <= new_sig);

    // Next slot content: hold unless the new entry lands at or below us.
    always_comb begin
        valid_d = valid_q;
        sig_d   = sig_q;
        idx_d   = idx_q;
        if (clear) begin
            valid_d = 1'b0;
            sig_d   = '0;
            idx_d   = '0;
        end else if (ins && !le) begin
            if (below_le) begin
                valid_d = 1'b1;
                sig_d   = new_sig;
                idx_d   = new_idx;
            end else begin
                valid_d = below_valid;
                sig_d   = below_sig;
                idx_d   = below_idx;
            end
        end
    end

    // Slot register.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            sig_q   <= '0;
            idx_q   <= '0;
        end else begin
            valid_q <= valid_d;
            sig_q   <= sig_d;
            idx_q   <= idx_d;
        end
    end
endmodule

// File: rtl/minhash_sorter.sv
// Keeps the K smallest signatures of a fragment and hands their indices to
// the extender after the fragment's last beat.
//
//   state   | meaning
//   COLLECT | accepting hasher beats, inserting each into the table
//   OUTPUT  | result presented to the extender, input stalled
module minhash_sorter
    import minhash_sorter_pkg::*;
#(
    parameter int K     = SORTER_EXTENDER_INDICES_COUNT,
    parameter int SIG_W = HASHER_SORTER_SIGNATURE,
    parameter int IDX_W = INDICE_LEN,
    parameter int CNT_W = $clog2(K+1)
) (
    input logic               clk,
    input logic               rst,
    minhash_sorter_if.slave   bus
);
    sorter_state_e state, state_nxt;

    logic             in_ready_q;
    logic             out_valid_q;
    logic [K*IDX_W-1:0] out_indices_q;
    logic [CNT_W-1:0] out_count_q;

    logic             accept;
    logic             clear;
    logic [SIG_W-1:0] new_sig;
    logic [IDX_W-1:0] new_idx;

    logic [K-1:0]     le;
    logic [K-1:0]     valid_q;
    logic [K-1:0]     valid_d;
    logic [SIG_W-1:0] sig_q [K];
    logic [IDX_W-1:0] idx_q [K];
    logic [IDX_W-1:0] idx_d [K];

    logic [K-1:0]     below_le;
    logic [K-1:0]     below_valid;
    logic [SIG_W-1:0] below_sig [K];
    logic [IDX_W-1:0] below_idx [K];

    logic [K*IDX_W-1:0] indices_nxt;
    logic [CNT_W-1:0]   count_nxt;

    // The top slot only ever gets discarded, so its outputs feed nothing.
    logic unused_top_slot;
    assign unused_top_slot = ^{le[K-1], valid_q[K-1], sig_q[K-1], idx_q[K-1]};

    assign accept  = bus.in_valid && in_ready_q;
    assign clear   = out_valid_q && bus.out_ready;
    assign new_sig = bus.in_data[SIG_W+IDX_W-1:IDX_W];
    assign new_idx = bus.in_data[IDX_W-1:0];

    // Slot 0 sees an always-true "below" compare so it can take the new entry.
    assign below_le    = {le[K-2:0], 1'b1};
    assign below_valid = {valid_q[K-2:0], 1'b0};

    for (genvar i = 0; i < K; i++) begin : g_slot
        if (i == 0) begin : g_floor
            assign below_sig[i] = '0;
            assign below_idx[i] = '0;
        end else begin : g_chain
            assign below_sig[i] = sig_q[i-1];
            assign below_idx[i] = idx_q[i-1];
        end

        sorter_slot_cell #(
            .SIG_W (SIG_W),
            .IDX_W (IDX_W)
        ) u_cell (
            .clk         (clk),
            .rst         (rst),
            .clear       (clear),
            .ins         (accept),
            .new_sig     (new_sig),
            .new_idx     (new_idx),
            .below_le    (below_le[i]),
            .below_valid (below_valid[i]),
            .below_sig   (below_sig[i]),
            .below_idx   (below_idx[i]),
            .le          (le[i]),
            .valid_q     (valid_q[i]),
            .sig_q       (sig_q[i]),
            .idx_q       (idx_q[i]),
            .valid_d     (valid_d[i]),
            .idx_d       (idx_d[i])
        );
    end

    // Pack the next table contents so the registered outputs track the table.
    always_comb begin
        indices_nxt = '0;
        count_nxt   = '0;
        for (int i = 0; i < K; i++) begin
            if (valid_d[i]) begin
                indices_nxt[i*IDX_W +: IDX_W] = idx_d[i];
                count_nxt = count_nxt + CNT_W'(1);
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            COLLECT: if (accept && bus.in_last) state_nxt = OUTPUT;
            OUTPUT:  if (clear)                 state_nxt = COLLECT;
            default: state_nxt = COLLECT;
        endcase
    end

    // State and registered handshake/result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= COLLECT;
            in_ready_q    <= 1'b0;
            out_valid_q   <= 1'b0;
            out_indices_q <= '0;
            out_count_q   <= '0;
        end else begin
            state         <= state_nxt;
            in_ready_q    <= (state_nxt == COLLECT);
            out_valid_q   <= (state_nxt == OUTPUT);
            out_indices_q <= indices_nxt;
            out_count_q   <= count_nxt;
        end
    end

    assign bus.in_ready    = in_ready_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_indices = out_indices_q;
    assign bus.out_count   = out_count_q;
endmodule

// File: tb/tb_minhash_sorter.sv
// Self-checking bench for minhash_sorter: vector table, scoreboard queue and
// a few hand-written multi-cycle sequences.
module tb_minhash_sorter;
    import minhash_sorter_pkg::*;

    localparam int K     = 4;
    localparam int IDX_W = 5;
    localparam int CNT_W = 3;
    localparam int MAXB  = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    minhash_sorter_if bus_if ();

    minhash_sorter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    typedef struct packed {
        logic [K*IDX_W-1:0] ind;
        logic [CNT_W-1:0]   cnt;
    } res_t;

    typedef struct {
        int                      n;
        logic [MAXB-1:0][31:0]   sig;
        logic [MAXB-1:0][4:0]    idx;
        logic [K*IDX_W-1:0]      exp_ind;
        logic [CNT_W-1:0]        exp_cnt;
    } vec_t;

    res_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: stable insertion into a K-deep ascending list.
    function automatic res_t model(input int n, input logic [MAXB-1:0][31:0] s,
                                   input logic [MAXB-1:0][4:0] ix);
        logic [31:0] ms [K];
        logic [4:0]  mi [K];
        int cnt = 0;
        int p;
        res_t r;
        for (int j = 0; j < K; j++) begin ms[j] = '0; mi[j] = '0; end
        for (int b = 0; b < n; b++) begin
            p = 0;
            while (p < cnt && ms[p] <= s[b]) p++;
            if (p < K) begin
                for (int j = K-1; j > p; j--) begin ms[j] = ms[j-1]; mi[j] = mi[j-1]; end
                ms[p] = s[b];
                mi[p] = ix[b];
                if (cnt < K) cnt++;
            end
        end
        r.ind = '0;
        for (int j = 0; j < cnt; j++) r.ind[j*IDX_W +: IDX_W] = mi[j];
        r.cnt = CNT_W'(cnt);
        return r;
    endfunction

    // Scoreboard: compare every completed handshake against the queue head.
    always @(negedge clk) begin
        if (rst === 1'b0 && bus_if.out_valid === 1'b1 && bus_if.out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_result", 32'd1, 32'd0);
            end else begin
                res_t e;
                e = exp_q.pop_front();
                check("out_indices", 32'(bus_if.out_indices), 32'(e.ind));
                check("out_count", 32'(bus_if.out_count), 32'(e.cnt));
            end
        end
    end

    // Called and returns just after a rising edge.
    task automatic send_beat(input logic [31:0] sig, input logic [4:0] idx,
                             input logic last, input bit stall);
        int g;
        if (stall) begin
            while ($urandom_range(0, 1) == 1) begin
                bus_if.in_valid = 1'b0;
                @(posedge clk); #1;
            end
        end
        bus_if.in_valid = 1'b1;
        bus_if.in_data  = pack_sig(sig, idx);
        bus_if.in_last  = last;
        g = 0;
        @(negedge clk);
        while (bus_if.in_ready !== 1'b1 && g < 100) begin
            @(negedge clk);
            g++;
        end
        if (g >= 100) check("in_ready_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        bus_if.in_valid = 1'b0;
        bus_if.in_last  = 1'b0;
    endtask

    task automatic send_frag(input int n, input logic [MAXB-1:0][31:0] s,
                             input logic [MAXB-1:0][4:0] ix, input bit stall);
        for (int b = 0; b < n; b++) send_beat(s[b], ix[b], (b == n-1), stall);
    endtask

    task automatic wait_drain();
        int g = 0;
        while (exp_q.size() != 0 && g < 100) begin
            @(negedge clk);
            g++;
        end
        if (exp_q.size() != 0) begin
            check("drain_timeout", 32'(exp_q.size()), 32'd0);
            exp_q.delete();
        end
        @(posedge clk); #1;
    endtask

    initial begin
        logic [MAXB-1:0][31:0] rs;
        logic [MAXB-1:0][4:0]  ri;
        logic [K*IDX_W-1:0]    hold_ind;
        logic [CNT_W-1:0]      hold_cnt;
        int g;

        vecs[0] = '{5, {32'h0, 32'h0, 32'h30, 32'h20, 32'h40, 32'h10, 32'h50} , 0, 0, 0};
        vecs[0].sig = '0; vecs[0].idx = '0;
        vecs[0].sig[0] = 32'h50; vecs[0].sig[1] = 32'h10; vecs[0].sig[2] = 32'h40;
        vecs[0].sig[3] = 32'h20; vecs[0].sig[4] = 32'h30;
        for (int b = 0; b < 5; b++) vecs[0].idx[b] = 5'(b);
        vecs[0].exp_ind = {5'd2, 5'd4, 5'd3, 5'd1}; vecs[0].exp_cnt = 3'd4;

        vecs[1].n = 3; vecs[1].sig = '0; vecs[1].idx = '0;
        vecs[1].sig[0] = 32'hFFFF_FFFF; vecs[1].sig[1] = 32'h7; vecs[1].sig[2] = 32'h7;
        vecs[1].idx[0] = 5'd0; vecs[1].idx[1] = 5'd1; vecs[1].idx[2] = 5'd2;
        vecs[1].exp_ind = {5'd0, 5'd0, 5'd2, 5'd1}; vecs[1].exp_cnt = 3'd3;

        vecs[2].n = 1; vecs[2].sig = '0; vecs[2].idx = '0;
        vecs[2].sig[0] = 32'h3;
        vecs[2].exp_ind = '0; vecs[2].exp_cnt = 3'd1;

        vecs[3].n = 5; vecs[3].sig = '0; vecs[3].idx = '0;
        for (int b = 0; b < 5; b++) begin vecs[3].sig[b] = 32'h8; vecs[3].idx[b] = 5'(b + 1); end
        vecs[3].exp_ind = {5'd4, 5'd3, 5'd2, 5'd1}; vecs[3].exp_cnt = 3'd4;

        vecs[4].n = 6; vecs[4].sig = '0; vecs[4].idx = '0;
        for (int b = 0; b < 6; b++) begin vecs[4].sig[b] = 32'(32'h60 - 32'h10 * b); vecs[4].idx[b] = 5'(b); end
        vecs[4].exp_ind = {5'd2, 5'd3, 5'd4, 5'd5}; vecs[4].exp_cnt = 3'd4;

        vecs[5].n = 2; vecs[5].sig = '0; vecs[5].idx = '0;
        vecs[5].sig[0] = 32'hFFFF_FFFF; vecs[5].idx[0] = 5'd7;
        vecs[5].sig[1] = 32'h0;         vecs[5].idx[1] = 5'd8;
        vecs[5].exp_ind = {5'd0, 5'd0, 5'd7, 5'd8}; vecs[5].exp_cnt = 3'd2;

        rst              = 1'b1;
        bus_if.in_valid  = 1'b0;
        bus_if.in_data   = '0;
        bus_if.in_last   = 1'b0;
        bus_if.out_ready = 1'b1;

        // Reset held for three cycles.
        @(posedge clk);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("rst_out_valid", 32'(bus_if.out_valid), 32'd0);
            check("rst_out_count", 32'(bus_if.out_count), 32'd0);
            check("rst_in_ready", 32'(bus_if.in_ready), 32'd0);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", 32'(bus_if.in_ready), 32'd0);
        @(negedge clk);
        check("post_rst_in_ready_rise", 32'(bus_if.in_ready), 32'd1);
        check("post_rst_out_indices", 32'(bus_if.out_indices), 32'd0);
        @(posedge clk); #1;

        // Vector table.
        for (int v = 0; v < 6; v++) begin
            exp_q.push_back({vecs[v].exp_ind, vecs[v].exp_cnt});
            send_frag(vecs[v].n, vecs[v].sig, vecs[v].idx, 1'b0);
            wait_drain();
        end

        // Backpressure, with a held beat (carrying last) that must not be taken.
        bus_if.out_ready = 1'b0;
        exp_q.push_back({vecs[0].exp_ind, vecs[0].exp_cnt});
        send_frag(vecs[0].n, vecs[0].sig, vecs[0].idx, 1'b0);
        g = 0;
        @(negedge clk);
        while (bus_if.out_valid !== 1'b1 && g < 20) begin @(negedge clk); g++; end
        check("bp_out_valid_rise", 32'(bus_if.out_valid), 32'd1);
        hold_ind = bus_if.out_indices;
        hold_cnt = bus_if.out_count;
        check("bp_first_indices", 32'(hold_ind), 32'(vecs[0].exp_ind));
        bus_if.in_valid = 1'b1;
        bus_if.in_data  = pack_sig(32'h0, 5'd9);
        bus_if.in_last  = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("bp_valid_stable", 32'(bus_if.out_valid), 32'd1);
            check("bp_indices_stable", 32'(bus_if.out_indices), 32'(hold_ind));
            check("bp_count_stable", 32'(bus_if.out_count), 32'(hold_cnt));
            check("bp_in_ready_low", 32'(bus_if.in_ready), 32'd0);
        end
        @(posedge clk); #1;
        bus_if.in_valid  = 1'b0;
        bus_if.in_last   = 1'b0;
        bus_if.out_ready = 1'b1;
        wait_drain();
        check("bp_after_out_valid", 32'(bus_if.out_valid), 32'd0);
        exp_q.push_back({20'd0, 3'd1});
        send_beat(32'h3, 5'd0, 1'b1, 1'b0);
        wait_drain();

        // Reset while a result is pending: no output pulse, nothing retained.
        bus_if.out_ready = 1'b0;
        send_frag(vecs[1].n, vecs[1].sig, vecs[1].idx, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        bus_if.out_ready = 1'b1;
        @(negedge clk);
        check("rst_output_valid", 32'(bus_if.out_valid), 32'd0);
        check("rst_output_count", 32'(bus_if.out_count), 32'd0);
        @(posedge clk); #1;

        // Reset in the middle of a fragment.
        send_beat(32'h1, 5'd1, 1'b0, 1'b0);
        send_beat(32'h2, 5'd2, 1'b0, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.push_back({5'd0, 5'd0, 5'd4, 5'd5, 3'd2});
        send_beat(32'h9, 5'd4, 1'b0, 1'b0);
        send_beat(32'h8, 5'd5, 1'b1, 1'b0);
        wait_drain();

        // Random fragments, each run unstalled and again with input stalls.
        for (int r = 0; r < 4; r++) begin
            rs = '0; ri = '0;
            for (int b = 0; b < 7; b++) begin
                rs[b] = 32'($urandom_range(0, 15));
                ri[b] = 5'($urandom_range(0, 31));
            end
            exp_q.push_back(model(7, rs, ri));
            send_frag(7, rs, ri, 1'b0);
            wait_drain();
            exp_q.push_back(model(7, rs, ri));
            send_frag(7, rs, ri, 1'b1);
            wait_drain();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
